plic_gateway_array: RTL and testbench

- Parametrised bank of N interrupt gateways sitting between external/peripheral interrupt lines and the PLIC core.
- Each source is independently configurable as level- or edge-triggered.
- Inputs have an optional synchroniser; edge mode uses a saturating pending counter so bursts of edges are not lost while a claim is in flight.
- Each source exposes the same valid/ready/complete handshake to the PLIC as the single-source level gateway.

---
 rtl/plic_gateway_array_if.sv | 53 +++++
 rtl/plic_gateway_array.sv | 136 +++++++++++++
 tb/tb_plic_gateway_array.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plic_gateway_array_if.sv
// -----------------------------------------------------------------------------
// plic_gateway_array_if
//
// Bundle of per-source interrupt lines and PLIC handshake signals for the
// gateway array. Every signal is N bits wide, one bit per interrupt source.
//
//   io_interrupt      raw interrupt lines (from peripherals)
//   io_mode           per-source trigger mode: 0 = level, 1 = rising edge
//   io_enable         per-source enable; 0 masks io_plic_valid
//   io_plic_valid     source requests a claim (to PLIC core)
//   io_plic_ready     PLIC core accepts the request
//   io_plic_complete  PLIC core signals completion of a claimed source
//   io_in_flight      source claimed and not yet completed
//   io_overflow       one-cycle pulse: an edge was lost to a saturated counter
//
// Modports:
//   master - drives lines, mode, enable, ready, complete (PLIC/environment side)
//   slave  - the gateway array itself
// -----------------------------------------------------------------------------
interface plic_gateway_array_if #(
    parameter int N = 8
);
    logic [N-1:0] io_interrupt;
    logic [N-1:0] io_mode;
    logic [N-1:0] io_enable;
    logic [N-1:0] io_plic_valid;
    logic [N-1:0] io_plic_ready;
    logic [N-1:0] io_plic_complete;
    logic [N-1:0] io_in_flight;
    logic [N-1:0] io_overflow;

    modport master (
        output io_interrupt,
        output io_mode,
        output io_enable,
        output io_plic_ready,
        output io_plic_complete,
        input  io_plic_valid,
        input  io_in_flight,
        input  io_overflow
    );

    modport slave (
        input  io_interrupt,
        input  io_mode,
        input  io_enable,
        input  io_plic_ready,
        input  io_plic_complete,
        output io_plic_valid,
        output io_in_flight,
        output io_overflow
    );
endinterface

// File: rtl/plic_gateway_array.sv
// -----------------------------------------------------------------------------
// plic_gateway_array
//
// Bank of N independent interrupt gateways between raw interrupt lines and the
// PLIC core. Each source is level- or rising-edge-triggered. Edge sources keep
// a saturating pending counter so bursts of edges arriving while a claim is in
// flight (or while masked) are not lost.
//
// Parameters:
//   N            number of sources (1..64)
//   SYNC_STAGES  synchroniser depth on the raw lines (0 = combinational bypass)
//   CNT_W        width of each edge pending counter (saturates at 2^CNT_W-1)
//
// Ports:
//   clk     clock
//   reset   synchronous, active-high reset
//   io_bus  plic_gateway_array_if slave modport (lines, mode, enable,
//           valid/ready/complete handshake, in-flight and overflow status)
// -----------------------------------------------------------------------------
module plic_gateway_array #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    plic_gateway_array_if.slave   io_bus
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    logic [N-1:0]     w_irqS;
    logic [N-1:0]     w_rise;
    logic [N-1:0]     w_valid;
    logic [N-1:0]     w_fire;
    logic [N-1:0]     w_ovfNext;
    logic [CNT_W-1:0] w_pendNext [N];

    logic [N-1:0]     r_prev;
    logic [N-1:0]     r_inFlight;
    logic [N-1:0]     r_overflow;
    logic [N-1:0]     r_modeReg;
    logic [CNT_W-1:0] r_pend [N];

    // Synchroniser chain for the raw lines. With zero stages the lines feed the
    // gateway logic directly, so level-mode valid becomes combinational from
    // the pins.
    generate
        if (SYNC_STAGES == 0) begin : g_noSync
            assign w_irqS = io_bus.io_interrupt;
        end else begin : g_sync
            logic [N-1:0] r_sync [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        r_sync[s] <= '0;
                    end
                end else begin
                    r_sync[0] <= io_bus.io_interrupt;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        r_sync[s] <= r_sync[s-1];
                    end
                end
            end

            assign w_irqS = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_rise = w_irqS & ~r_prev;

    // Request generation. Level sources present the synchronised line itself;
    // edge sources present "something is pending". Both are suppressed while a
    // claim is outstanding or the source is masked.
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < N; i++) begin
            w_valid[i] = io_bus.io_enable[i] & ~r_inFlight[i] &
                         (io_bus.io_mode[i] ? (r_pend[i] != '0) : w_irqS[i]);
        end
    end

    assign w_fire = w_valid & io_bus.io_plic_ready;

    // Pending-counter update. A mode change (or level mode) discards any count.
    // A rise and a fire in the same cycle cancel. A rise into a full counter is
    // dropped and flagged. A fire can only happen with a non-zero count, so the
    // decrement never wraps.
    always_comb begin
        w_ovfNext = '0;
        for (int i = 0; i < N; i++) begin
            w_pendNext[i] = r_pend[i];
            if ((io_bus.io_mode[i] != r_modeReg[i]) || !io_bus.io_mode[i]) begin
                w_pendNext[i] = '0;
            end else if (w_rise[i] && !w_fire[i]) begin
                if (r_pend[i] == PEND_MAX) begin
                    w_ovfNext[i] = 1'b1;
                end else begin
                    w_pendNext[i] = r_pend[i] + PEND_ONE;
                end
            end else if (!w_rise[i] && w_fire[i]) begin
                w_pendNext[i] = r_pend[i] - PEND_ONE;
            end
        end
    end

    // Per-source state. In-flight is set by a fire and cleared by complete;
    // since fire requires in-flight to be low, a complete arriving together
    // with a fire is necessarily spurious and the fire wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= '0;
            r_inFlight <= '0;
            r_overflow <= '0;
            r_modeReg  <= '0;
            for (int i = 0; i < N; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            r_prev     <= w_irqS;
            r_inFlight <= w_fire | (r_inFlight & ~io_bus.io_plic_complete);
            r_overflow <= w_ovfNext;
            r_modeReg  <= io_bus.io_mode;
            for (int i = 0; i < N; i++) begin
                r_pend[i] <= w_pendNext[i];
            end
        end
    end

    assign io_bus.io_plic_valid = w_valid;
    assign io_bus.io_in_flight  = r_inFlight;
    assign io_bus.io_overflow   = r_overflow;

endmodule

// File: tb/tb_plic_gateway_array.sv
// -----------------------------------------------------------------------------
// tb_plic_gateway_array
//
// Self-checking bench for plic_gateway_array. A behavioural model tracks each
// source as integers and bit vectors; every cycle the stimulus side pushes the
// model's expected outputs into a queue and a monitor on the falling edge pops
// and compares them against the DUT. Directed scenarios are followed by a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_plic_gateway_array;

    localparam int N           = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 3;
    localparam int PEND_MAX    = (1 << CNT_W) - 1;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] inFlight;
        logic [N-1:0] overflow;
        int           cyc;
    } exp_t;

    logic clk;
    logic reset;

    plic_gateway_array_if #(.N(N)) bus ();

    plic_gateway_array #(
        .N           (N),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;
    int cycleNo = 0;

    exp_t expQ[$];

    // Reference model state: plain counts and flags per source.
    int           mPend [N];
    logic [N-1:0] mInFlight;
    logic [N-1:0] mOvf;
    logic [N-1:0] mModeReg;
    logic [N-1:0] mPrev;
    logic [N-1:0] mHist[$];
    bit           mKnown = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h",
                     name, cycleNo, actual, expected);
        end
    endtask

    // Line value as seen after the synchroniser: what was on the pin
    // SYNC_STAGES clock edges ago.
    function automatic logic [N-1:0] modelIrqS();
        if (SYNC_STAGES == 0) return bus.io_interrupt;
        return mHist[SYNC_STAGES-1];
    endfunction

    function automatic logic [N-1:0] modelValid();
        logic [N-1:0] v;
        logic [N-1:0] s;
        s = modelIrqS();
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.io_enable[i] && !mInFlight[i]) begin
                if (bus.io_mode[i]) v[i] = (mPend[i] > 0);
                else                v[i] = s[i];
            end
        end
        return v;
    endfunction

    task automatic modelUpdate();
        logic [N-1:0] s;
        logic [N-1:0] v;
        int           n;
        bit           fire;
        bit           rise;
        if (reset) begin
            for (int i = 0; i < N; i++) mPend[i] = 0;
            mInFlight = '0;
            mOvf      = '0;
            mModeReg  = '0;
            mPrev     = '0;
            mHist.delete();
            for (int k = 0; k < SYNC_STAGES; k++) mHist.push_back('0);
            mKnown = 1;
        end else if (mKnown) begin
            s = modelIrqS();
            v = modelValid();
            for (int i = 0; i < N; i++) begin
                fire = v[i] && bus.io_plic_ready[i];
                rise = s[i] && !mPrev[i];
                mOvf[i] = 1'b0;
                if (bus.io_mode[i] != mModeReg[i] || !bus.io_mode[i]) begin
                    mPend[i] = 0;
                end else begin
                    n = mPend[i] + int'(rise) - int'(fire);
                    if (n > PEND_MAX) begin
                        n = PEND_MAX;
                        mOvf[i] = 1'b1;
                    end
                    mPend[i] = n;
                end
                if (fire)                      mInFlight[i] = 1'b1;
                else if (bus.io_plic_complete[i]) mInFlight[i] = 1'b0;
            end
            mModeReg = bus.io_mode;
            mPrev    = s;
            if (SYNC_STAGES > 0) begin
                mHist.push_front(bus.io_interrupt);
                void'(mHist.pop_back());
            end
        end
    endtask

    // One clock cycle: record what the model expects for the current inputs,
    // advance the model on the edge, and return just after the edge so the
    // caller can change inputs for the next cycle.
    task automatic applyStimulus();
        exp_t e;
        if (mKnown) begin
            e.valid    = modelValid();
            e.inFlight = mInFlight;
            e.overflow = mOvf;
            e.cyc      = cycleNo;
            expQ.push_back(e);
        end
        @(posedge clk);
        modelUpdate();
        cycleNo++;
        #1;
    endtask

    // Monitor: outputs are presented every cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("sb_valid",    64'(bus.io_plic_valid), 64'(e.valid));
            checkOutput("sb_in_flight", 64'(bus.io_in_flight), 64'(e.inFlight));
            checkOutput("sb_overflow", 64'(bus.io_overflow),   64'(e.overflow));
        end
    end

    // Runs a fixed number of claim/complete rounds on one source and reports
    // how many claims were actually granted.
    task automatic serveClaims(input int src, input int rounds, output int served);
        served = 0;
        for (int r = 0; r < rounds; r++) begin
            bus.io_plic_ready[src] = 1'b1;
            applyStimulus();
            bus.io_plic_ready[src] = 1'b0;
            if (bus.io_in_flight[src]) begin
                served++;
                bus.io_plic_complete[src] = 1'b1;
                applyStimulus();
                bus.io_plic_complete[src] = 1'b0;
            end
        end
    endtask

    task automatic pulseEdges(input int src, input int count);
        for (int k = 0; k < count; k++) begin
            bus.io_interrupt[src] = 1'b1;
            applyStimulus();
            bus.io_interrupt[src] = 1'b0;
            applyStimulus();
        end
    endtask

    initial begin
        int served;
        int ovfCount;

        reset                = 1'b1;
        bus.io_interrupt     = '0;
        bus.io_mode          = '0;
        bus.io_enable        = '1;
        bus.io_plic_ready    = '0;
        bus.io_plic_complete = '0;
        repeat (3) applyStimulus();
        reset = 1'b0;
        checkOutput("reset_valid",    64'(bus.io_plic_valid), 64'h0);
        checkOutput("reset_in_flight", 64'(bus.io_in_flight), 64'h0);
        checkOutput("reset_overflow", 64'(bus.io_overflow),   64'h0);

        // Level path on source 0.
        bus.io_interrupt[0] = 1'b1;
        applyStimulus();
        checkOutput("level_not_early", 64'(bus.io_plic_valid[0]), 64'h0);
        applyStimulus();
        checkOutput("level_latency", 64'(bus.io_plic_valid[0]), 64'h1);
        bus.io_plic_ready[0] = 1'b1;
        applyStimulus();
        bus.io_plic_ready[0] = 1'b0;
        checkOutput("level_claimed", 64'(bus.io_in_flight[0]), 64'h1);
        checkOutput("level_masked_in_flight", 64'(bus.io_plic_valid[0]), 64'h0);
        applyStimulus();
        bus.io_plic_complete[0] = 1'b1;
        applyStimulus();
        bus.io_plic_complete[0] = 1'b0;
        checkOutput("level_completed", 64'(bus.io_in_flight[0]), 64'h0);
        checkOutput("level_reassert", 64'(bus.io_plic_valid[0]), 64'h1);
        bus.io_interrupt[0] = 1'b0;
        repeat (3) applyStimulus();

        // Edge burst on source 3.
        bus.io_mode[3] = 1'b1;
        applyStimulus();
        pulseEdges(3, 3);
        repeat (3) applyStimulus();
        checkOutput("edge_burst_valid", 64'(bus.io_plic_valid[3]), 64'h1);
        serveClaims(3, 8, served);
        checkOutput("edge_burst_served", 64'(served), 64'd3);
        checkOutput("edge_burst_drained", 64'(bus.io_plic_valid[3]), 64'h0);

        // Saturation on source 5: two edges are lost.
        bus.io_mode[5] = 1'b1;
        applyStimulus();
        ovfCount = 0;
        for (int k = 0; k < 9; k++) begin
            bus.io_interrupt[5] = 1'b1;
            applyStimulus();
            ovfCount += int'(bus.io_overflow[5]);
            bus.io_interrupt[5] = 1'b0;
            applyStimulus();
            ovfCount += int'(bus.io_overflow[5]);
        end
        repeat (4) begin
            applyStimulus();
            ovfCount += int'(bus.io_overflow[5]);
        end
        checkOutput("sat_overflow_pulses", 64'(ovfCount), 64'd2);
        serveClaims(5, 12, served);
        checkOutput("sat_served", 64'(served), 64'd7);

        // Rise and fire in the same cycle on source 3 with two pending.
        pulseEdges(3, 2);
        repeat (2) applyStimulus();
        bus.io_interrupt[3] = 1'b1;
        applyStimulus();
        bus.io_interrupt[3] = 1'b0;
        applyStimulus();
        bus.io_plic_ready[3] = 1'b1;
        applyStimulus();
        bus.io_plic_ready[3] = 1'b0;
        checkOutput("rise_fire_claimed", 64'(bus.io_in_flight[3]), 64'h1);
        bus.io_plic_complete[3] = 1'b1;
        applyStimulus();
        bus.io_plic_complete[3] = 1'b0;
        serveClaims(3, 6, served);
        checkOutput("rise_fire_pend_kept", 64'(served), 64'd2);

        // Spurious complete with fire on source 1; sources 1 and 6 together.
        bus.io_interrupt[1] = 1'b1;
        bus.io_interrupt[6] = 1'b1;
        repeat (2) applyStimulus();
        bus.io_plic_ready[1]    = 1'b1;
        bus.io_plic_ready[6]    = 1'b1;
        bus.io_plic_complete[1] = 1'b1;
        applyStimulus();
        bus.io_plic_ready    = '0;
        bus.io_plic_complete = '0;
        checkOutput("spurious_complete_fire", 64'(bus.io_in_flight[1]), 64'h1);
        checkOutput("dual_fire", 64'({bus.io_in_flight[6], bus.io_in_flight[1]}), 64'h3);
        bus.io_interrupt[1] = 1'b0;
        bus.io_interrupt[6] = 1'b0;
        bus.io_plic_complete[1] = 1'b1;
        bus.io_plic_complete[6] = 1'b1;
        applyStimulus();
        bus.io_plic_complete = '0;

        // Enable masking on a level source.
        bus.io_enable[2]    = 1'b0;
        bus.io_interrupt[2] = 1'b1;
        repeat (3) applyStimulus();
        checkOutput("enable_masked", 64'(bus.io_plic_valid[2]), 64'h0);
        bus.io_enable[2] = 1'b1;
        #1;
        checkOutput("enable_unmasked", 64'(bus.io_plic_valid[2]), 64'h1);
        bus.io_interrupt[2] = 1'b0;
        repeat (3) applyStimulus();

        // Mode change discards the pending count on source 4.
        bus.io_mode[4]   = 1'b1;
        bus.io_enable[4] = 1'b0;
        applyStimulus();
        pulseEdges(4, 4);
        repeat (3) applyStimulus();
        bus.io_mode[4] = 1'b0;
        applyStimulus();
        bus.io_mode[4]   = 1'b1;
        bus.io_enable[4] = 1'b1;
        applyStimulus();
        checkOutput("mode_change_cleared", 64'(bus.io_plic_valid[4]), 64'h0);
        repeat (2) applyStimulus();

        // Reset mid-claim.
        bus.io_interrupt[0] = 1'b1;
        repeat (2) applyStimulus();
        bus.io_plic_ready[0] = 1'b1;
        applyStimulus();
        bus.io_plic_ready[0] = 1'b0;
        bus.io_interrupt[0]  = 1'b0;
        pulseEdges(3, 2);
        repeat (3) applyStimulus();
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        checkOutput("mid_reset_valid",    64'(bus.io_plic_valid), 64'h0);
        checkOutput("mid_reset_in_flight", 64'(bus.io_in_flight), 64'h0);
        repeat (4) applyStimulus();
        checkOutput("mid_reset_no_replay", 64'(bus.io_plic_valid[3]), 64'h0);

        // Randomized phase against the model.
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0)  bus.io_interrupt[i] = ~bus.io_interrupt[i];
                if ($urandom_range(0, 99) == 0) bus.io_mode[i] = ~bus.io_mode[i];
                bus.io_enable[i]        = ($urandom_range(0, 7) != 0);
                bus.io_plic_ready[i]    = 1'($urandom_range(0, 1));
                bus.io_plic_complete[i] = ($urandom_range(0, 3) == 0);
            end
            applyStimulus();
        end
        reset = 1'b0;
        applyStimulus();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
